// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, W clocks per result.
// A zero divisor short-circuits straight to DONE with a flagged, saturated quotient.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring step per cycle, W steps total
// DONE  | results loaded, done pulses; start accepted back-to-back
module seq_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  prem_q, prem_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;

  logic [W:0]    shifted;
  logic [W:0]    trial;
  logic          qbit;

  always_comb begin
    shifted = {prem_q, dvd_q[W-1]};
    trial   = shifted - {1'b0, dvs_q};
    // A carry out of the shift guarantees the subtraction fits; otherwise the borrow decides.
    qbit    = shifted[W] | ~trial[W];

    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (y == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = x;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
            dvd_d   = x;
            dvs_d   = y;
            prem_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      CALC: begin
        dvd_d  = {dvd_q[W-2:0], qbit};
        prem_d = qbit ? trial[W-1:0] : shifted[W-1:0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          quot_d  = dvd_d;
          rem_d   = prem_d;
          dz_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign quot     = quot_q;
  assign rem      = rem_q;
  assign div_zero = dz_q;
  assign busy     = (state_q == CALC);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: hand-computed quotients, latency, busy length,
// ignored mid-calculation start, back-to-back start, async reset and a random sweep.
module tb_seq_div;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] x, y;
  logic [15:0] quot, rem;
  logic        busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  seq_div #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
    .quot(quot), .rem(rem), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives start at the current negedge and waits (bounded) for done.
  task automatic run_div(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                         input logic [15:0] eq, input logic [15:0] er, input logic edz,
                         input int elat, input int ign_at);
    int  n;
    int  bcnt;
    bit  seen;
    n = 0; bcnt = 0; seen = 1'b0;
    x = xv; y = yv; start = 1'b1;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      n = k;
      if (k == 1) start = 1'b0;
      if (ign_at != 0 && k == ign_at) begin start = 1'b1; x = 16'd50; y = 16'd5; end
      if (ign_at != 0 && k == ign_at + 1) start = 1'b0;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(n - 1), 32'(elat));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(elat));
    chk({tag, "_quot"}, 32'(quot), 32'(eq));
    chk({tag, "_rem"}, 32'(rem), 32'(er));
    chk({tag, "_div_zero"}, 32'(div_zero), 32'(edz));
  endtask

  task automatic idle_chk(input string tag, input logic [15:0] eq, input logic [15:0] er);
    @(negedge clk);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_quot_hold"}, 32'(quot), 32'(eq));
    chk({tag, "_rem_hold"}, 32'(rem), 32'(er));
  endtask

  initial begin
    int          dcnt;
    logic [15:0] xv, yv;
    logic [31:0] recon;

    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, 0);
    run_div("b2b_81_9", 16'd81, 16'd9, 16'd9, 16'd0, 1'b0, 16, 0);
    idle_chk("after_b2b", 16'd9, 16'd0);

    run_div("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16, 0);
    run_div("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 16, 0);
    idle_chk("after_ffff", 16'd1, 16'd0);

    run_div("y0_5", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0, 0);
    run_div("after_y0_9_4", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0, 16, 0);
    idle_chk("after_9_4", 16'd2, 16'd1);

    run_div("x0_5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 16, 0);
    run_div("ign_3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 16, 5);
    idle_chk("after_ign", 16'd0, 16'd3);
    run_div("y0_pre_rst", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0, 0);
    idle_chk("pre_rst", 16'hFFFF, 16'd5);

    // Abandon a division with an asynchronous reset in the middle of CALC.
    x = 16'd1000; y = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_quot", 32'(quot), 32'd0);
    chk("async_rem", 32'(rem), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_dz", 32'(div_zero), 32'd0);
    start = 1'b1;
    @(negedge clk);
    chk("rst_start_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    dcnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("no_done_after_rst", 32'(dcnt), 32'd0);

    for (int i = 0; i < 8; i++) begin
      xv = 16'($urandom);
      yv = 16'($urandom_range(1, 65535));
      if (i == 0) xv = 16'd7;
      run_div("rand", xv, yv, xv / yv, xv % yv, 1'b0, 16, 0);
      recon = 32'(quot) * 32'(yv) + 32'(rem);
      chk("rand_recon", recon, 32'(xv));
      chk("rand_rem_lt_y", 32'(rem < yv), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter W, default 16: operand and result width.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request a division; sampled on rising clk.
REQ-005 SHALL have port x, input, W: unsigned dividend; captured on an accepted start.
REQ-006 SHALL have port y, input, W: unsigned divisor; captured on an accepted start.
REQ-007 SHALL have port quot, output, W: quotient, registered.
REQ-008 SHALL have port rem, output, W: remainder, registered.
REQ-009 SHALL have port busy, output, 1: high while a division is in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse; results valid.
REQ-011 SHALL have port div_zero, output, 1: last completed division had y=0; registered.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in CALC SHALL be ignored, with no effect on operands, counter or results.
REQ-014 On an accepted start with y!=0, SHALL capture x and y, clear the partial remainder, load the iteration counter with 0, and enter CALC.
REQ-015 In CALC, SHALL perform one restoring-division step per cycle: shift {partial remainder, dividend} left by 1, form a W+1-bit trial difference (partial remainder minus divisor), keep the difference if non-negative and set the quotient bit to 1, otherwise restore and set the quotient bit to 0.
REQ-016 SHALL perform exactly W steps; the edge performing step W SHALL load quot/rem and enter DONE.
REQ-017 SHALL assert done in the cycle after the accepting edge + W edges, i.e. latency W cycles (16 for default W), for exactly one cycle.
REQ-018 On an accepted start with y=0, SHALL go directly to DONE on the accepting edge with quot = all-ones, rem = x, div_zero=1 (latency 1 cycle).
REQ-019 SHALL clear div_zero when a division with y!=0 completes.
REQ-020 SHALL keep quot, rem and div_zero unchanged, except on entry to DONE.
REQ-021 SHALL hold busy=1 exactly while in CALC, and 0 in IDLE and DONE.
REQ-022 DONE SHALL last one cycle: go to IDLE if start=0, or accept start back-to-back per REQ-014/REQ-018.
REQ-023 SHALL guarantee quot*y + rem = x and rem < y for all y!=0, including x=0 and x<y (quot=0, rem=x).
REQ-024 Internal arithmetic SHALL use W+1 bits so that trial subtraction never loses the borrow for any divisor up to 2^W-1.

Reset
REQ-025 While rst_n=0, SHALL immediately force state IDLE and quot=0, rem=0, busy=0, done=0, div_zero=0, counter=0, independent of clk.
REQ-026 Reset asserted mid-CALC SHALL abandon the operation; after release SHALL produce no done until a new start is accepted.
REQ-027 SHALL ignore start on the first edge where rst_n is low, and SHALL sample normally from the first edge after release.

Verification
REQ-028 Scenario: x=100, y=7, start for 1 cycle -> busy for 16 cycles, done pulse at cycle 16, quot=14, rem=2, div_zero=0.
REQ-029 Scenario: x=16'hFFFF, y=1 -> quot=16'hFFFF, rem=0; then x=16'hFFFF, y=16'hFFFF -> quot=1, rem=0.
REQ-030 Scenario: x=5, y=0 -> done in next cycle, busy never asserted, quot=16'hFFFF, rem=5, div_zero=1; then x=9, y=4 -> quot=2, rem=1, div_zero=0.
REQ-031 Scenario: x=3, y=10 started; start pulsed with x=50, y=5 at cycle 5 of CALC -> ignored, result quot=0, rem=3.
REQ-032 Scenario: start in the DONE cycle with x=81, y=9 -> busy next cycle, quot=9, rem=0 after 16 cycles, no IDLE gap.
REQ-033 Scenario: rst_n low at cycle 8 of CALC -> all outputs 0 asynchronously, no done afterwards; random x/y sweep checked against quot*y+rem=x, rem<y.
